// File: rtl/bisr_ru_allocator_if.sv
`default_nettype none
// ============================================================================
// Module : bisr_ru_allocator_if
// Brief  : STW fault-matrix input and redundant-unit assignment outputs.
// Rev    : 1.0
// ============================================================================
interface bisr_ru_allocator_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4
);
  localparam int NUM_BITS_COLS = $clog2(COLS);
  localparam int CNT_W         = $clog2(COLS + 1);

  logic                            stw_complete;
  logic [ROWS*COLS-1:0]            stw_result_mat;
  logic [NUM_RU-1:0]               ru_en;
  logic [NUM_BITS_COLS*NUM_RU-1:0] ru_col_mapping;
  logic [COLS-1:0]                 col_remapped;
  logic [CNT_W-1:0]                fault_count;
  logic                            alloc_busy;
  logic                            alloc_done;
  logic                            alloc_overflow;

  modport master (
    output stw_complete, stw_result_mat,
    input  ru_en, ru_col_mapping, col_remapped, fault_count,
           alloc_busy, alloc_done, alloc_overflow
  );

  modport slave (
    input  stw_complete, stw_result_mat,
    output ru_en, ru_col_mapping, col_remapped, fault_count,
           alloc_busy, alloc_done, alloc_overflow
  );
endinterface
`default_nettype wire

// File: rtl/bisr_ru_allocator.sv
`default_nettype none
// ============================================================================
// Module : bisr_ru_allocator
// Brief  : Scans the latched STW fault matrix one column per cycle and hands
//          each faulty column the next free redundant unit.
// Rev    : 1.0
// ============================================================================
module bisr_ru_allocator #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int NUM_RU = 4
) (
  input  logic                clk,
  input  logic                rst,
  bisr_ru_allocator_if.slave  io
);
  localparam int NUM_BITS_COLS = $clog2(COLS);
  localparam int CNT_W         = $clog2(COLS + 1);
  localparam int RU_W          = $clog2(NUM_RU + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                          r_state;
  logic                            r_stw_prev;
  logic [ROWS*COLS-1:0]            r_mat;
  logic [NUM_BITS_COLS-1:0]        r_col_idx;
  logic [RU_W-1:0]                 r_next_ru;
  logic [NUM_RU-1:0]               r_ru_en;
  logic [NUM_BITS_COLS*NUM_RU-1:0] r_map;
  logic [COLS-1:0]                 r_col_remapped;
  logic [CNT_W-1:0]                r_fault_count;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_overflow;

  logic                            w_start;
  logic [COLS-1:0]                 w_col_any;
  logic                            w_col_faulty;
  logic                            w_ru_avail;

  assign w_start    = io.stw_complete & ~r_stw_prev;
  assign w_ru_avail = (r_next_ru < RU_W'(NUM_RU));

  always_comb begin
    w_col_any = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        w_col_any[c] = w_col_any[c] | r_mat[r*COLS + c];
      end
    end
  end

  always_comb begin
    w_col_faulty = 1'b0;
    for (int c = 0; c < COLS; c++) begin
      if (r_col_idx == NUM_BITS_COLS'(c)) begin
        w_col_faulty = w_col_any[c];
      end
    end
  end

  // stw_prev resets high so a level already asserted at reset release is not a start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_stw_prev     <= 1'b1;
      r_mat          <= '0;
      r_col_idx      <= '0;
      r_next_ru      <= '0;
      r_ru_en        <= '0;
      r_map          <= '0;
      r_col_remapped <= '0;
      r_fault_count  <= '0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_stw_prev <= io.stw_complete;
      if (w_start) begin
        r_state        <= S_SCAN;
        r_mat          <= io.stw_result_mat;
        r_col_idx      <= '0;
        r_next_ru      <= '0;
        r_ru_en        <= '0;
        r_map          <= '0;
        r_col_remapped <= '0;
        r_fault_count  <= '0;
        r_busy         <= 1'b1;
        r_done         <= 1'b0;
        r_overflow     <= 1'b0;
      end else begin
        case (r_state)
          S_SCAN: begin
            if (w_col_faulty) begin
              r_fault_count <= r_fault_count + CNT_W'(1);
              if (w_ru_avail) begin
                for (int i = 0; i < NUM_RU; i++) begin
                  if (r_next_ru == RU_W'(i)) begin
                    r_ru_en[i]                                  <= 1'b1;
                    r_map[i*NUM_BITS_COLS +: NUM_BITS_COLS]     <= r_col_idx;
                  end
                end
                for (int c = 0; c < COLS; c++) begin
                  if (r_col_idx == NUM_BITS_COLS'(c)) begin
                    r_col_remapped[c] <= 1'b1;
                  end
                end
                r_next_ru <= r_next_ru + RU_W'(1);
              end else begin
                // Unserved column keeps its faulty output; only flag it.
                r_overflow <= 1'b1;
              end
            end
            if (r_col_idx == NUM_BITS_COLS'(COLS - 1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_col_idx <= r_col_idx + NUM_BITS_COLS'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign io.ru_en          = r_ru_en;
  assign io.ru_col_mapping = r_map;
  assign io.col_remapped   = r_col_remapped;
  assign io.fault_count    = r_fault_count;
  assign io.alloc_busy     = r_busy;
  assign io.alloc_done     = r_done;
  assign io.alloc_overflow = r_overflow;
endmodule
`default_nettype wire
